// File: rtl/sample_ringbuf.sv
// Two-channel (L/R) audio sample ring buffer with per-channel pointers, fill levels and sticky error flags.
// A pop is answered one cycle later, and an empty buffer answers with silence; data_o is zero whenever there is no ack.
module sample_ringbuf #(
  parameter int DATA_W     = 24,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic [1:0]            push_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [1:0]            full_o,
  input  logic [1:0]            pop_i,
  output logic [DATA_W-1:0]     data_o,
  output logic [1:0]            ack_o,
  output logic [DEPTH_LOG2:0]   level0_o,
  output logic [DEPTH_LOG2:0]   level1_o,
  output logic [1:0]            underrun_o,
  output logic [1:0]            overflow_o
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  logic [DATA_W-1:0]     mem [2][DEPTH];
  logic [DEPTH_LOG2-1:0] rptr [2];
  logic [DEPTH_LOG2-1:0] wptr [2];
  logic [DEPTH_LOG2:0]   cnt [2];
  logic [DEPTH_LOG2:0]   cnt_nxt [2];

  logic [1:0]        push_c;
  logic [1:0]        pop_c;
  logic [1:0]        empty;
  logic [1:0]        full_now;
  logic [1:0]        wr_ok;
  logic [1:0]        rd_ok;
  logic [DATA_W-1:0] rd_dat;

  // Both strobes high resolves to channel 0 only.
  assign push_c = {push_i[1] & ~push_i[0], push_i[0]};
  assign pop_c  = {pop_i[1] & ~pop_i[0], pop_i[0]};

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      empty[c]    = (cnt[c] == '0);
      full_now[c] = (cnt[c] == DEPTH_CNT);
      rd_ok[c]    = pop_c[c] & ~empty[c];
      // A pop in the same cycle frees the slot a full-buffer push needs.
      wr_ok[c]    = push_c[c] & (~full_now[c] | pop_c[c]);
      cnt_nxt[c]  = cnt[c];
      if (wr_ok[c] && !rd_ok[c]) begin
        cnt_nxt[c] = cnt[c] + CNT_ONE;
      end else if (rd_ok[c] && !wr_ok[c]) begin
        cnt_nxt[c] = cnt[c] - CNT_ONE;
      end
    end
  end

  always_comb begin
    rd_dat = '0;
    if (rd_ok[0]) begin
      rd_dat = mem[0][rptr[0]];
    end else if (rd_ok[1]) begin
      rd_dat = mem[1][rptr[1]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        rptr[c] <= '0;
        wptr[c] <= '0;
        cnt[c]  <= '0;
      end
      full_o     <= '0;
      ack_o      <= '0;
      data_o     <= '0;
      underrun_o <= '0;
      overflow_o <= '0;
    end else if (clear_i) begin
      for (int c = 0; c < 2; c++) begin
        rptr[c] <= '0;
        wptr[c] <= '0;
        cnt[c]  <= '0;
      end
      full_o     <= '0;
      ack_o      <= pop_c;
      data_o     <= '0;
      underrun_o <= '0;
      overflow_o <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (rd_ok[c]) rptr[c] <= rptr[c] + PTR_ONE;
        if (wr_ok[c]) wptr[c] <= wptr[c] + PTR_ONE;
        cnt[c]    <= cnt_nxt[c];
        full_o[c] <= (cnt_nxt[c] == DEPTH_CNT);
      end
      ack_o      <= pop_c;
      data_o     <= rd_dat;
      underrun_o <= underrun_o | (pop_c & empty);
      overflow_o <= overflow_o | (push_c & full_now & ~pop_c);
    end
  end

  // Storage is not reset; its contents are only observable through valid entries.
  always_ff @(posedge clk) begin
    if (rst && !clear_i) begin
      for (int c = 0; c < 2; c++) begin
        if (wr_ok[c]) mem[c][wptr[c]] <= wdata_i;
      end
    end
  end

  assign level0_o = cnt[0];
  assign level1_o = cnt[1];

endmodule

// File: tb/tb_sample_ringbuf.sv
// Randomized and directed bench for sample_ringbuf, checked against a queue-based model with an ack scoreboard.
module tb_sample_ringbuf;

  localparam int DW    = 24;
  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear_i = 1'b0;
  logic [1:0]    push_i = '0;
  logic [DW-1:0] wdata_i = '0;
  logic [1:0]    full_o;
  logic [1:0]    pop_i = '0;
  logic [DW-1:0] data_o;
  logic [1:0]    ack_o;
  logic [DL2:0]  level0_o;
  logic [DL2:0]  level1_o;
  logic [1:0]    underrun_o;
  logic [1:0]    overflow_o;

  sample_ringbuf #(.DATA_W(DW), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .push_i(push_i), .wdata_i(wdata_i),
    .full_o(full_o), .pop_i(pop_i), .data_o(data_o), .ack_o(ack_o),
    .level0_o(level0_o), .level1_o(level1_o),
    .underrun_o(underrun_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            ch;
    logic [DW-1:0] dat;
    int            due;
  } exp_t;

  exp_t          sb [$];
  logic [DW-1:0] mq [2][$];
  logic [1:0]    m_uf;
  logic [1:0]    m_of;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ack must match the oldest outstanding pop that is due.
  always @(negedge clk) begin
    if (rst) begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("ack", {30'd0, ack_o}, 32'(1 << e.ch));
        chk("ack_data", {8'd0, data_o}, {8'd0, e.dat});
      end else begin
        chk("ack_idle", {30'd0, ack_o}, 32'd0);
        chk("data_idle", {8'd0, data_o}, 32'd0);
      end
    end
  end

  task automatic model_clear();
    mq[0].delete();
    mq[1].delete();
    m_uf = '0;
    m_of = '0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_level0"}, 32'(level0_o), 32'(mq[0].size()));
    chk({tag, "_level1"}, 32'(level1_o), 32'(mq[1].size()));
    chk({tag, "_full"}, {30'd0, full_o},
        {30'd0, mq[1].size() == DEPTH, mq[0].size() == DEPTH});
    chk({tag, "_underrun"}, {30'd0, underrun_o}, {30'd0, m_uf});
    chk({tag, "_overflow"}, {30'd0, overflow_o}, {30'd0, m_of});
  endtask

  // Called just after a rising edge; applies inputs for one cycle and predicts the result.
  task automatic step(input logic [1:0] push, input logic [1:0] pop,
                      input logic [DW-1:0] wd, input logic clr);
    int pc;
    int qc;
    exp_t e;
    push_i  = push;
    pop_i   = pop;
    wdata_i = wd;
    clear_i = clr;
    pc = (push[0]) ? 0 : (push[1] ? 1 : -1);
    qc = (pop[0])  ? 0 : (pop[1]  ? 1 : -1);
    if (qc >= 0) begin
      e.ch  = qc;
      e.due = cyc + 1;
      e.dat = '0;
      if (!clr) begin
        if (mq[qc].size() == 0) m_uf[qc] = 1'b1;
        else e.dat = mq[qc].pop_front();
      end
      sb.push_back(e);
    end
    if (clr) begin
      model_clear();
    end else if (pc >= 0) begin
      if (mq[pc].size() < DEPTH) mq[pc].push_back(wd);
      else m_of[pc] = 1'b1;
    end
    @(posedge clk);
    #1;
    push_i  = '0;
    pop_i   = '0;
    clear_i = 1'b0;
    check_status("st");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, '0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"}, {30'd0, ack_o}, 32'd0);
    chk({tag, "_data"}, {8'd0, data_o}, 32'd0);
    chk({tag, "_full"}, {30'd0, full_o}, 32'd0);
    chk({tag, "_lvl0"}, 32'(level0_o), 32'd0);
    chk({tag, "_lvl1"}, 32'(level1_o), 32'd0);
    chk({tag, "_flags"}, {28'd0, underrun_o, overflow_o}, 32'd0);
  endtask

  initial begin
    model_clear();
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Three pushes then three back-to-back pops on L.
    for (int i = 1; i <= 3; i++) step(2'b01, 2'b00, DW'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(2'b00, 2'b01, '0, 1'b0);
    idle(2);

    // Overfill R by one, then drain it.
    for (int i = 0; i < 17; i++) step(2'b10, 2'b00, DW'(24'h100 + i), 1'b0);
    for (int i = 0; i < 16; i++) step(2'b00, 2'b10, '0, 1'b0);
    idle(2);

    // Empty pop on L returns silence and flags underrun.
    step(2'b00, 2'b01, '0, 1'b0);
    idle(2);

    // Full L with simultaneous push and pop.
    step(2'b00, 2'b00, '0, 1'b1);
    for (int i = 0; i < 16; i++) step(2'b01, 2'b00, DW'(24'hA00 + i), 1'b0);
    step(2'b01, 2'b01, 24'hABCDEF, 1'b0);
    for (int i = 0; i < 16; i++) step(2'b00, 2'b01, '0, 1'b0);
    idle(2);

    // Reset while a pop response is in flight.
    step(2'b01, 2'b00, 24'h555555, 1'b0);
    step(2'b00, 2'b01, '0, 1'b0);
    rst = 1'b0;
    sb.delete();
    model_clear();
    #1;
    check_all_zero("inrst");
    #20;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("postrst");
    step(2'b01, 2'b00, 24'h123456, 1'b0);
    step(2'b00, 2'b01, '0, 1'b0);
    idle(2);

    // Alternating L/R pops with pushes on the other channel, wrapping the pointers.
    step(2'b00, 2'b00, '0, 1'b1);
    for (int i = 0; i < 10; i++) step(2'b01, 2'b00, DW'(24'h10000 + i), 1'b0);
    for (int i = 0; i < 10; i++) step(2'b10, 2'b00, DW'(24'h20000 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) step(2'b10, 2'b01, DW'(24'h20100 + i), 1'b0);
      else            step(2'b01, 2'b10, DW'(24'h10100 + i), 1'b0);
    end
    idle(2);

    // Random traffic, including both-bit strobes and occasional clears.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] p;
      logic [1:0] q;
      logic       c;
      p = ($urandom_range(0, 9) < 6) ? 2'($urandom) : 2'b00;
      q = ($urandom_range(0, 9) < 5) ? 2'($urandom) : 2'b00;
      c = ($urandom_range(0, 199) == 0);
      step(p, q, DW'($urandom), c);
    end
    idle(3);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule

// File: doc/sample_ringbuf.md
SAMPLE_RINGBUF -- requirements
Module: sample_ringbuf

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning sample width.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of entries per channel (16).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous flush of both channels.
REQ-006 SHALL have port push_i  input  2  write strobe per channel (bit0 = L, bit1 = R).
REQ-007 SHALL have port wdata_i  input  DATA_W  sample written on push.
REQ-008 SHALL have port full_o  output  2  per-channel full flag.
REQ-009 SHALL have port pop_i  input  2  read request per channel, one-cycle pulse.
REQ-010 SHALL have port data_o  output  DATA_W  response sample, valid only while the matching ack_o bit is high.
REQ-011 SHALL have port ack_o  output  2  one-cycle response strobe per channel.
REQ-012 SHALL have port level0_o / level1_o  output  DEPTH_LOG2+1  fill count of L / R.
REQ-013 SHALL have port underrun_o / overflow_o  output  2  sticky per-channel error flags.

Function
REQ-014 SHALL keep an independent circular buffer per channel: read pointer, write pointer, count; pointers wrap modulo 2^DEPTH_LOG2.
REQ-015 Push on channel c with count < depth SHALL store wdata_i at wptr[c], advance wptr[c], increment count[c].
REQ-016 Push when full SHALL drop the sample, leave pointers and count unchanged, and set overflow_o[c].
REQ-017 push_i = 2'b11 SHALL be treated as push on channel 0 only.
REQ-018 Pop on channel c SHALL produce ack_o[c] = 1 exactly one cycle later, with data_o = entry at rptr[c] sampled at the pop cycle.
REQ-019 Pop when count[c] = 0 SHALL still ack one cycle later with data_o = 0 (silence), pointers unchanged, underrun_o[c] set.
REQ-020 Non-empty pop SHALL advance rptr[c] and decrement count[c].
REQ-021 pop_i = 2'b11 SHALL serve channel 0 only; bit 1 ignored.
REQ-022 Back-to-back pops on consecutive cycles SHALL be supported, one ack per pop, throughput 1 per cycle.
REQ-023 Simultaneous push and pop, same channel, non-empty and not full: count unchanged, both pointers advance.
REQ-024 Simultaneous push and pop, same channel, empty: pop returns silence plus underrun; push stored; count becomes 1.
REQ-025 Simultaneous push and pop, same channel, full: pop frees an entry; push accepted, no overflow; count stays at depth.
REQ-026 When ack_o = 2'b00, data_o SHALL be 0 so several responders can be OR-combined.
REQ-027 full_o[c] SHALL equal (count[c] == depth), and levelN_o SHALL equal count[N], both registered and current after each edge.
REQ-028 clear_i SHALL zero pointers, counts and sticky flags on the next edge; push or pop in that cycle SHALL be ignored except that a pop still acks silence.
REQ-029 Underrun and overflow flags SHALL remain set until clear_i or reset.

Reset
REQ-030 rst low SHALL immediately force ack_o = 0, data_o = 0, full_o = 0, levels = 0, flags = 0, all pointers = 0; storage contents are don't-care.
REQ-031 A pop in flight when rst asserts SHALL produce no ack after reset release.
REQ-032 The first edge after rst deassertion SHALL accept push and pop normally.

Verification
REQ-033 Push L 0x000001..0x000003, then pop L three times on consecutive cycles -> ack_o = 01 on the three following cycles with data 0x000001, 0x000002, 0x000003; level0 returns to 0.
REQ-034 Push R 17 times with DEPTH_LOG2 = 4 -> full_o[1] = 1 after the 16th push; the 17th is dropped; overflow_o[1] = 1; the 16 pops return the first 16 values in order.
REQ-035 Pop L on an empty buffer -> next cycle ack_o = 01, data_o = 0, underrun_o[0] = 1; level0 stays 0.
REQ-036 Fill L to 16, then push+pop L in the same cycle -> no overflow; level0 stays 16; the ack carries the oldest sample.
REQ-037 Pop L at cycle n, rst low at n+1 -> no ack; all outputs 0; after release push/pop works from empty.
REQ-038 Interleave pop L / pop R on alternate cycles with wrap past index 15 -> each ack bit matches its request, data per channel in FIFO order; no cross-channel mixing.
